// File: rtl/bi_link_dir_ctrl.sv
// Direction controller for one bidirectional BiNoC link: arbitrates ownership,
// bounds the owner's hold time under contention and inserts dead cycles on reversal.
module bi_link_dir_ctrl #(
    parameter int HOLD_MAX    = 8,
    parameter int TURN_CYCLES = 2,
    parameter int INIT_DIR    = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic             req2,
    output logic             inout_select1,
    output logic             inout_select2,
    output logic             grant1,
    output logic             grant2,
    output logic             dir,
    output logic             turn_busy,
    output logic [CNT_W-1:0] turn_count
);

    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int TW = $clog2(TURN_CYCLES + 1);

    typedef enum logic [1:0] {
        OWN1,
        OWN2,
        TURN12,
        TURN21
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [TW-1:0]    turn_q, turn_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= (INIT_DIR != 0) ? OWN2 : OWN1;
            hold_q  <= '0;
            turn_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        count_d = count_q;

        unique case (state_q)
            OWN1: begin
                if (req2 && (!req1 || hold_q == HW'(HOLD_MAX - 1))) begin
                    state_d = TURN12;
                    hold_d  = '0;
                    turn_d  = '0;
                end else if (req1 && req2) begin
                    hold_d = hold_q + HW'(1);
                end else begin
                    hold_d = '0;
                end
            end
            OWN2: begin
                if (req1 && (!req2 || hold_q == HW'(HOLD_MAX - 1))) begin
                    state_d = TURN21;
                    hold_d  = '0;
                    turn_d  = '0;
                end else if (req1 && req2) begin
                    hold_d = hold_q + HW'(1);
                end else begin
                    hold_d = '0;
                end
            end
            TURN12, TURN21: begin
                // Requests are ignored here: a started reversal always completes.
                if (turn_q == TW'(TURN_CYCLES - 1)) begin
                    state_d = (state_q == TURN12) ? OWN2 : OWN1;
                    turn_d  = '0;
                    hold_d  = '0;
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
            default: state_d = OWN1;
        endcase
    end

    always_comb begin
        inout_select1 = 1'b0;
        inout_select2 = 1'b0;
        grant1        = 1'b0;
        grant2        = 1'b0;
        dir           = 1'b0;
        turn_busy     = 1'b0;

        unique case (state_q)
            OWN1: begin
                inout_select1 = 1'b1;
                grant1        = req1;
            end
            OWN2: begin
                inout_select2 = 1'b1;
                grant2        = req2;
                dir           = 1'b1;
            end
            TURN12: begin
                turn_busy = 1'b1;
            end
            TURN21: begin
                dir       = 1'b1;
                turn_busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign turn_count = count_q;

endmodule
